// File: rtl/mc_main_ctrl.sv
// Main control FSM for the multicycle MIPS datapath: Moore decode of a 4-bit state
// with memory-handshake stretching and an optional wait timeout. Optional addi support: MC_MAIN_CTRL_ADDI_EN.
module mc_main_ctrl #(
    parameter int unsigned WAIT_LIMIT = 0,
    parameter int unsigned CNT_W      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic [1:0] ALUOp,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic       PCWrite,
    output logic       Branch,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       mem_timeout
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_LIMIT);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d;
    logic             wait_st, stall, timeout;

    assign wait_st = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    assign stall   = wait_st && !mem_ready;
    // a completing handshake always beats the timeout
    assign timeout = stall && (WAIT_LIMIT != 0) && (wcnt_q == LIMIT);
    assign state   = state_q;

    always_comb begin
        state_d     = S_FETCH;
        ALUOp       = 2'b00;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        PCSrc       = 2'b00;
        PCWrite     = 1'b0;
        Branch      = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;
        mem_timeout = 1'b0;

        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                state_d = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
`ifdef MC_MAIN_CTRL_ADDI_EN
                    OP_ADDI:      state_d = S_ADDIEX;
`endif
                    default: begin
                        illegal_op = 1'b1;
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                state_d = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                MemtoReg   = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ready;
                state_d    = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegDst     = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUOp      = 2'b01;
                PCSrc      = 2'b01;
                Branch     = 1'b1;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                PCSrc      = 2'b10;
                PCWrite    = 1'b1;
                instr_done = 1'b1;
            end
`ifdef MC_MAIN_CTRL_ADDI_EN
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
`endif
            default: state_d = S_FETCH;
        endcase

        if (timeout) begin
            mem_timeout = 1'b1;
            IRWrite     = 1'b0;
            PCWrite     = 1'b0;
            instr_done  = 1'b0;
            state_d     = S_FETCH;
        end

        if (reset) begin
            PCWrite     = 1'b0;
            IRWrite     = 1'b0;
            RegWrite    = 1'b0;
            MemWrite    = 1'b0;
            MemRead     = 1'b0;
            instr_done  = 1'b0;
            illegal_op  = 1'b0;
            mem_timeout = 1'b0;
        end
    end

    // timeout returns FETCH to FETCH, so it needs its own counter clear
    always_comb begin
        wcnt_d = wcnt_q;
        if (state_d != state_q || timeout)
            wcnt_d = '0;
        else if (stall && wcnt_q != {CNT_W{1'b1}})
            wcnt_d = wcnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Randomized bench for mc_main_ctrl against an instruction-plan reference model.
module tb_mc_main_ctrl;

    localparam int LIMIT  = 3;
    localparam int CYCLES = 4000;

    typedef struct packed {
        logic [1:0] aluop;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] pcsrc;
        logic       pcw, br, iord, mrd, mwr, irw, m2r, rdst, rw, done, ill, tmo;
    } ctl_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic       mem_ready;
    logic [1:0] ALUOp, ALUSrcB, PCSrc;
    logic       ALUSrcA, PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, instr_done, illegal_op, mem_timeout;
    logic [3:0] state;

    int checks   = 0;
    int failures = 0;

    mc_main_ctrl #(.WAIT_LIMIT(LIMIT), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
        .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
        .PCWrite(PCWrite), .Branch(Branch), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
        .RegDst(RegDst), .RegWrite(RegWrite), .state(state),
        .instr_done(instr_done), .illegal_op(illegal_op), .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at t=%0t: got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    function automatic bit is_illegal(input logic [5:0] o);
        case (o)
            6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010: return 1'b0;
`ifdef MC_MAIN_CTRL_ADDI_EN
            6'b001000: return 1'b0;
`endif
            default: return 1'b1;
        endcase
    endfunction

    // reference model: current step plus the remaining steps of the instruction
    int cur;
    int rest[$];
    int wcnt;

    function automatic bit is_mem(input int s);
        return (s == 0) || (s == 3) || (s == 5);
    endfunction

    function automatic ctl_t expect_ctl(input int s, input bit rst, input bit rdy,
                                        input logic [5:0] o, input int wc);
        ctl_t e;
        e = '0;
        case (s)
            0: begin e.mrd = 1; e.srcb = 2'b01; e.irw = rdy; e.pcw = rdy; end
            1: begin e.srcb = 2'b11; e.ill = is_illegal(o); e.done = is_illegal(o); end
            2: begin e.srca = 1; e.srcb = 2'b10; end
            3: begin e.mrd = 1; e.iord = 1; end
            4: begin e.m2r = 1; e.rw = 1; e.done = 1; end
            5: begin e.mwr = 1; e.iord = 1; e.done = rdy; end
            6: begin e.srca = 1; e.aluop = 2'b10; end
            7: begin e.rdst = 1; e.rw = 1; e.done = 1; end
            8: begin e.srca = 1; e.aluop = 2'b01; e.pcsrc = 2'b01; e.br = 1; e.done = 1; end
            9: begin e.pcsrc = 2'b10; e.pcw = 1; e.done = 1; end
`ifdef MC_MAIN_CTRL_ADDI_EN
            10: begin e.srca = 1; e.srcb = 2'b10; end
            11: begin e.rw = 1; e.done = 1; end
`endif
            default: ;
        endcase
        if (is_mem(s) && !rdy && wc == LIMIT) e.tmo = 1;
        if (rst) begin
            e.pcw = 0; e.irw = 0; e.rw = 0; e.mwr = 0; e.mrd = 0;
            e.done = 0; e.ill = 0; e.tmo = 0;
        end
        return e;
    endfunction

    task automatic model_step(input bit rst, input bit rdy, input logic [5:0] o);
        if (rst) begin
            cur = 0; rest.delete(); wcnt = 0;
        end else if (is_mem(cur) && !rdy) begin
            if (wcnt == LIMIT) begin
                cur = 0; rest.delete(); wcnt = 0;
            end else if (wcnt < 255) begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
            if (cur == 0) begin
                cur = 1;
                rest.delete();
                case (o)
                    6'b000000: rest = '{6, 7};
                    6'b100011: rest = '{2, 3, 4};
                    6'b101011: rest = '{2, 5};
                    6'b000100: rest = '{8};
                    6'b000010: rest = '{9};
`ifdef MC_MAIN_CTRL_ADDI_EN
                    6'b001000: rest = '{10, 11};
`endif
                    default: ;
                endcase
            end else begin
                cur = (rest.size() != 0) ? rest.pop_front() : 0;
            end
        end
    endtask

    logic [5:0] op_tab [7];
    ctl_t obs, exp_c;
    int   n_tmo, n_done;

    initial begin
        op_tab = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                   6'b000010, 6'b001000, 6'b111111};
        n_tmo = 0; n_done = 0;
        reset = 1'b1; mem_ready = 1'b1; op = 6'b000000;
        cur = 0; wcnt = 0;
        @(posedge clk);
        for (int i = 0; i < CYCLES; i++) begin
            #1;
            reset = (i < 2) ? 1'b1 : ($urandom_range(0, 149) == 0);
            // first stretch runs with the handshake always ready
            mem_ready = (i < 400) ? 1'b1 : ($urandom_range(0, 9) < 6);
            if (cur == 0)
                op = ($urandom_range(0, 7) == 7) ? 6'($urandom) : op_tab[$urandom_range(0, 6)];
            @(negedge clk);
            exp_c = expect_ctl(cur, reset, mem_ready, op, wcnt);
            obs = {ALUOp, ALUSrcA, ALUSrcB, PCSrc, PCWrite, Branch, IorD, MemRead,
                   MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
                   instr_done, illegal_op, mem_timeout};
            chk("state", 32'(state), 32'(cur));
            chk("ctl", 32'(obs), 32'(exp_c));
            if (exp_c.tmo) n_tmo++;
            if (exp_c.done) n_done++;
            model_step(reset, mem_ready, op);
            @(posedge clk);
        end
        $display("info: instructions=%0d timeouts=%0d", n_done, n_tmo);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_main_ctrl.md
Name: mc_main_ctrl

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the 2-bit ALUOp consumed by aluctr, plus all mux selects and write strobes.
- Stretches memory states until the memory handshake completes.

Parameters:
- WAIT_LIMIT, 0, maximum wait cycles in a memory state before abort; 0 disables the timeout.
- CNT_W, 8, width of the wait counter; WAIT_LIMIT must be < 2^CNT_W.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- op  input  6  opcode, IR[31:26]
- mem_ready  input  1  memory completes the current access this cycle
- ALUOp  output  2  to aluctr: 00 add, 01 sub, 10 use funct
- ALUSrcA  output  1  0 = PC, 1 = A register
- ALUSrcB  output  2  00 = B, 01 = const 4, 10 = signext imm, 11 = signext imm<<2
- PCSrc  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite  output  1 each  datapath controls
- state  output  4  current state code, for debug
- instr_done  output  1  one-cycle pulse on the last cycle of each instruction
- illegal_op  output  1  one-cycle pulse in DECODE on an unsupported opcode
- mem_timeout  output  1  one-cycle pulse when a memory wait is aborted

Behaviour:
- Registered 4-bit state; outputs are a combinational Moore decode of state, plus the mem_ready gating listed below.
- Reset:
  - next edge with reset=1 sets state to FETCH (0) and clears the wait counter.
  - While reset=1, PCWrite, IRWrite, RegWrite, MemWrite, MemRead, instr_done, illegal_op and mem_timeout are forced to 0.
  - Reset mid-instruction abandons the instruction; there is no partial writeback.
- Unlisted controls are 0.
- States and transitions:
  - FETCH (0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00. IRWrite=PCWrite=mem_ready. Stay while mem_ready=0; otherwise go to DECODE.
  - DECODE (1): ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target precompute). Next state by op:
    - 100011/101011 -> MEMADR
    - 000000 -> EXEC
    - 000100 -> BRANCH
    - 000010 -> JUMP
    - 001000 -> ADDIEX (only when the macro is defined)
    - any other op -> FETCH with illegal_op=1 and instr_done=1
  - MEMADR (2): ALUSrcA=1, ALUSrcB=10, ALUOp=00. lw -> MEMRD; sw -> MEMWR.
  - MEMRD (3): MemRead=1, IorD=1. Wait for mem_ready, then go to MEMWB.
  - MEMWB (4): RegDst=0, MemtoReg=1, RegWrite=1, instr_done=1 -> FETCH.
  - MEMWR (5): MemWrite=1, IorD=1. Wait for mem_ready, then go to FETCH with instr_done=1 in the completing cycle.
  - EXEC (6): ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> ALUWB.
  - ALUWB (7): RegDst=1, MemtoReg=0, RegWrite=1, instr_done=1 -> FETCH.
  - BRANCH (8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1, instr_done=1 -> FETCH.
  - JUMP (9): PCSrc=10, PCWrite=1, instr_done=1 -> FETCH.
  - ADDIEX (10) and ADDIWB (11): see Optional Feature.
  - Codes 12-15: illegal state; next state FETCH, all strobes 0.
- Latency with mem_ready tied to 1:
  - R-type 4 cycles, lw 5, sw 4, beq 3, j 3.
  - Each wait cycle in FETCH, MEMRD or MEMWR adds 1.
- Wait counter:
  - Increments each cycle spent in FETCH, MEMRD or MEMWR with mem_ready=0.
  - Clears on any state change.
  - If WAIT_LIMIT != 0 and the counter equals WAIT_LIMIT while mem_ready=0: mem_timeout=1, no strobes complete, next state FETCH.
  - mem_ready=1 in the same cycle wins over the timeout.
  - The counter saturates at its maximum value, never wraps.

Optional Feature:
- Macro MC_MAIN_CTRL_ADDI_EN.
- Defined:
  - op 001000 in DECODE -> ADDIEX.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> ADDIWB.
  - ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1, instr_done=1 -> FETCH.
  - addi latency is 4 cycles.
- Not defined: op 001000 takes the illegal-opcode path, and state codes 10/11 behave as illegal states.

Test Plan:
- Reset, then mem_ready=1, op=000000 -> state 0,1,6,7,0. ALUOp=10 in state 6. RegWrite=1 and RegDst=1 in state 7. instr_done pulses once.
- op=100011, mem_ready low 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0. MemRead=1 and IorD=1 throughout state 3. RegWrite and MemtoReg=1 in state 4.
- op=000100 -> states 0,1,8,0. ALUOp=01, PCSrc=01, Branch=1 in state 8. op=000010 -> state 9 with PCSrc=10 and PCWrite=1.
- op=111111 -> illegal_op=1 for one cycle in state 1, then FETCH, with no RegWrite or MemWrite asserted at any point.
- WAIT_LIMIT=3, mem_ready=0 in FETCH -> mem_timeout at the 4th FETCH cycle, IRWrite=PCWrite=0 throughout; a second trial with mem_ready=1 in that same cycle -> normal DECODE, no timeout.
- reset=1 asserted in MEMWR -> next cycle state 0 and MemWrite never asserted after the reset edge. With the macro defined, op=001000 -> states 0,1,10,11,0 and RegWrite=1 in state 11.
